// File: rtl/vga_fb_port_arbiter.sv
// Port-A sequencer for the VGA frame-buffer RAM: arbitrates CPU single accesses
// against a hardware range fill, with the CPU always preempting the fill.
module vga_fb_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic                  cpu_ready_o,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  input  logic                  fill_start_i,
  input  logic [ADDR_WIDTH-1:0] fill_base_i,
  input  logic [ADDR_WIDTH:0]   fill_len_i,
  input  logic [DATA_WIDTH-1:0] fill_value_i,
  output logic                  fill_busy_o,
  output logic                  fill_done_o,
  output logic [ADDR_WIDTH-1:0] ram_addra_o,
  output logic [DATA_WIDTH-1:0] ram_dina_o,
  output logic                  ram_wea_o,
  input  logic [DATA_WIDTH-1:0] ram_douta_i
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CPU_WR  = 3'd1;
  localparam logic [2:0] S_CPU_RD1 = 3'd2;
  localparam logic [2:0] S_CPU_RD2 = 3'd3;
  localparam logic [2:0] S_FILL    = 3'd4;

  localparam logic [ADDR_WIDTH:0] REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [2:0]            state_q, state_d;
  logic                  cpu_ready_q, cpu_ready_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic                  fill_busy_q, fill_busy_d;
  logic                  fill_done_q, fill_done_d;
  logic [ADDR_WIDTH-1:0] ram_addra_q, ram_addra_d;
  logic [DATA_WIDTH-1:0] ram_dina_q, ram_dina_d;
  logic                  ram_wea_q, ram_wea_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic                  cpu_accept;
  logic                  fill_accept;
  logic [2:0]            resume_state;

  assign cpu_accept  = cpu_req_i && !cpu_ready_q && ((state_q == S_IDLE) || (state_q == S_FILL));
  assign fill_accept = fill_start_i && !fill_busy_q;

  // Next-state and output-register computation
  always_comb begin
    state_d     = state_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    fill_busy_d = fill_busy_q;
    fill_done_d = 1'b0;
    ram_addra_d = ram_addra_q;
    ram_dina_d  = ram_dina_q;
    ram_wea_d   = 1'b0;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    value_d     = value_q;

    // busy stays up through the cycle that carries the last write and its done pulse
    if (fill_done_q) begin
      fill_busy_d = 1'b0;
    end else begin
      fill_busy_d = fill_busy_q;
    end

    if (fill_accept) begin
      ptr_d   = fill_base_i;
      rem_d   = fill_len_i;
      value_d = fill_value_i;
      if (fill_len_i != '0) begin
        fill_busy_d = 1'b1;
      end else begin
        fill_done_d = 1'b1;
      end
    end else begin
      value_d = value_q;
    end

    resume_state = (fill_busy_d && (rem_d != '0)) ? S_FILL : S_IDLE;

    case (state_q)
      S_IDLE, S_FILL: begin
        if (cpu_accept) begin
          ram_addra_d = cpu_addr_i;
          if (cpu_we_i) begin
            ram_wea_d   = 1'b1;
            ram_dina_d  = cpu_wdata_i;
            cpu_ready_d = 1'b1;
            state_d     = S_CPU_WR;
          end else begin
            state_d = S_CPU_RD1;
          end
        end else if ((state_q == S_FILL) && (rem_q != '0)) begin
          ram_wea_d   = 1'b1;
          ram_addra_d = ptr_q;
          ram_dina_d  = value_q;
          ptr_d       = ptr_q + 1'b1;
          rem_d       = rem_q - 1'b1;
          if (rem_q == REM_ONE) begin
            fill_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = resume_state;
        end
      end
      S_CPU_WR: begin
        state_d = resume_state;
      end
      S_CPU_RD1: begin
        state_d = S_CPU_RD2;
      end
      S_CPU_RD2: begin
        cpu_rdata_d = ram_douta_i;
        cpu_ready_d = 1'b1;
        state_d     = resume_state;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      fill_busy_q <= 1'b0;
      fill_done_q <= 1'b0;
      ram_addra_q <= '0;
      ram_dina_q  <= '0;
      ram_wea_q   <= 1'b0;
      ptr_q       <= '0;
      rem_q       <= '0;
      value_q     <= '0;
    end else begin
      state_q     <= state_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      fill_busy_q <= fill_busy_d;
      fill_done_q <= fill_done_d;
      ram_addra_q <= ram_addra_d;
      ram_dina_q  <= ram_dina_d;
      ram_wea_q   <= ram_wea_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      value_q     <= value_d;
    end
  end

  assign cpu_ready_o = cpu_ready_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign fill_busy_o = fill_busy_q;
  assign fill_done_o = fill_done_q;
  assign ram_addra_o = ram_addra_q;
  assign ram_dina_o  = ram_dina_q;
  assign ram_wea_o   = ram_wea_q;

endmodule

// File: tb/tb_vga_fb_port_arbiter.sv
// Scoreboard bench for vga_fb_port_arbiter: a driver pushes expected RAM writes and
// CPU responses; a negedge monitor pops and compares whatever the DUT presents.
module tb_vga_fb_port_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we, cpu_ready;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          fill_start, fill_busy, fill_done;
  logic [AW-1:0] fill_base;
  logic [AW:0]   fill_len;
  logic [DW-1:0] fill_value;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dina;
  logic          ram_wea;
  logic [DW-1:0] ram_douta = 8'h00;
  logic [DW-1:0] mem [16] = '{default: 8'h00};

  always #5 clk = ~clk;

  vga_fb_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ready_o(cpu_ready), .cpu_rdata_o(cpu_rdata),
    .fill_start_i(fill_start), .fill_base_i(fill_base), .fill_len_i(fill_len),
    .fill_value_i(fill_value), .fill_busy_o(fill_busy), .fill_done_o(fill_done),
    .ram_addra_o(ram_addra), .ram_dina_o(ram_dina), .ram_wea_o(ram_wea),
    .ram_douta_i(ram_douta)
  );

  // 16x8 frame-buffer RAM, port A, registered read
  always @(posedge clk) begin
    if (ram_wea) mem[ram_addra] <= ram_dina;
    ram_douta <= mem[ram_addra];
  end

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { bit rd; logic [DW-1:0] d; } rsp_t;

  wr_t  fill_q[$];
  wr_t  cpu_wr_q[$];
  rsp_t rsp_q[$];
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] last_rd = 8'h00;
  int compared = 0, mismatched = 0;
  int wr_cycles = 0, fill_wr_seen = 0, zero_done_pend = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bad(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: every DUT write and CPU completion is matched against the queues
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (ram_wea) begin
          wr_t w;
          wr_cycles++;
          if (cpu_ready) begin
            if (cpu_wr_q.size() == 0) bad("unexpected_cpu_write");
            else begin
              w = cpu_wr_q.pop_front();
              check("cpu_wr_addr", 32'(ram_addra), 32'(w.a));
              check("cpu_wr_data", 32'(ram_dina), 32'(w.d));
              check("done_on_cpu_wr", 32'(fill_done), 32'd0);
            end
          end else begin
            if (fill_q.size() == 0) bad("unexpected_fill_write");
            else begin
              w = fill_q.pop_front();
              fill_wr_seen++;
              check("fill_wr_addr", 32'(ram_addra), 32'(w.a));
              check("fill_wr_data", 32'(ram_dina), 32'(w.d));
              check("fill_done_last", 32'(fill_done), 32'(fill_q.size() == 0));
            end
          end
        end else if (fill_done) begin
          if (zero_done_pend > 0) zero_done_pend--;
          else bad("spurious_fill_done");
        end
        if (cpu_ready) begin
          rsp_t r;
          if (rsp_q.size() == 0) bad("unexpected_cpu_ready");
          else begin
            r = rsp_q.pop_front();
            if (r.rd) begin
              check("cpu_rdata", 32'(cpu_rdata), 32'(r.d));
              last_rd = r.d;
            end else begin
              check("rdata_hold", 32'(cpu_rdata), 32'(last_rd));
              check("wr_ready_wea", 32'(ram_wea), 32'd1);
            end
          end
        end
      end
    end
  end

  task automatic cpu_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int   lat;
    rsp_t r;
    wr_t  w;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    if (we) begin
      ref_mem[a] = d;
      w.a = a; w.d = d;
      cpu_wr_q.push_back(w);
      r.rd = 1'b0; r.d = d;
    end else begin
      r.rd = 1'b1; r.d = ref_mem[a];
    end
    rsp_q.push_back(r);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_ready && lat < 20);
    cpu_req = 1'b0;
    check(we ? "wr_latency" : "rd_latency", 32'(lat), we ? 32'd1 : 32'd3);
  endtask

  task automatic fill_go(input logic [AW-1:0] b, input logic [AW:0] len, input logic [DW-1:0] v,
                         input bit apply);
    wr_t w;
    @(negedge clk);
    fill_start = 1'b1; fill_base = b; fill_len = len; fill_value = v;
    for (int i = 0; i < int'(len); i++) begin
      w.a = b + AW'(i);
      w.d = v;
      fill_q.push_back(w);
      if (apply) ref_mem[w.a] = v;
    end
    if (len == 5'd0) zero_done_pend++;
    @(negedge clk);
    fill_start = 1'b0;
    if (len != 5'd0) check("busy_after_start", 32'(fill_busy), 32'd1);
  endtask

  task automatic wait_fill_idle();
    int n = 0;
    while ((fill_busy || fill_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) bad("fill_timeout");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, s0, n, nops;
    logic [AW-1:0] b, a;
    logic [AW:0]   len;
    logic [DW-1:0] v;

    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    fill_start = 1'b0; fill_base = '0; fill_len = '0; fill_value = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_fill_busy", 32'(fill_busy), 32'd0);
    check("rst_fill_done", 32'(fill_done), 32'd0);
    check("rst_ram_addra", 32'(ram_addra), 32'd0);
    check("rst_ram_dina", 32'(ram_dina), 32'd0);
    check("rst_ram_wea", 32'(ram_wea), 32'd0);
    rst_n = 1'b1;

    // basic CPU write then read
    cpu_op(1'b1, 4'd3, 8'hA5);
    cpu_op(1'b0, 4'd3, 8'h00);

    // fill 2..5 with exact cycle-by-cycle timing
    fill_go(4'd2, 5'd4, 8'h3C, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("f1_wea", 32'(ram_wea), 32'd1);
      check("f1_addr", 32'(ram_addra), 32'(2 + i));
      check("f1_done", 32'(fill_done), 32'(i == 3));
    end
    @(negedge clk);
    check("f1_wea_after", 32'(ram_wea), 32'd0);
    check("f1_busy_after", 32'(fill_busy), 32'd0);
    for (int i = 1; i <= 6; i++) cpu_op(1'b0, AW'(i), 8'h00);

    // wrapping fill
    fill_go(4'd14, 5'd4, 8'h11, 1'b1);
    wait_fill_idle();
    cpu_op(1'b0, 4'd15, 8'h00);
    cpu_op(1'b0, 4'd0, 8'h00);
    cpu_op(1'b0, 4'd1, 8'h00);
    cpu_op(1'b0, 4'd13, 8'h00);

    // full fill preempted by a CPU write; the fill reaches addr 8 after the CPU write
    w0 = wr_cycles;
    fill_go(4'd0, 5'd16, 8'hFF, 1'b0);
    @(negedge clk);
    cpu_op(1'b1, 4'd8, 8'h07);
    wait_fill_idle();
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'hFF;
    check("contended_wr_cycles", 32'(wr_cycles - w0), 32'd17);
    cpu_op(1'b0, 4'd8, 8'h00);
    cpu_op(1'b0, 4'd2, 8'h00);
    cpu_op(1'b0, 4'd15, 8'h00);

    // zero-length fill
    w0 = wr_cycles;
    fill_go(4'd5, 5'd0, 8'h77, 1'b1);
    check("len0_done", 32'(fill_done), 32'd1);
    check("len0_busy", 32'(fill_busy), 32'd0);
    @(negedge clk);
    check("len0_done_gone", 32'(fill_done), 32'd0);
    check("len0_busy2", 32'(fill_busy), 32'd0);
    check("len0_no_writes", 32'(wr_cycles - w0), 32'd0);

    // fill_start while busy must be ignored
    fill_go(4'd4, 5'd8, 8'h66, 1'b1);
    fill_start = 1'b1; fill_base = 4'd0; fill_len = 5'd3; fill_value = 8'hEE;
    @(negedge clk);
    fill_start = 1'b0;
    wait_fill_idle();
    cpu_op(1'b0, 4'd4, 8'h00);
    cpu_op(1'b0, 4'd11, 8'h00);
    cpu_op(1'b0, 4'd0, 8'h00);

    // reset after two of eight fill writes
    s0 = fill_wr_seen;
    fill_go(4'd0, 5'd8, 8'h5A, 1'b0);
    n = 0;
    while ((fill_wr_seen - s0) < 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (n >= 50) bad("reset_wait_timeout");
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("mid_rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("mid_rst_fill_busy", 32'(fill_busy), 32'd0);
    check("mid_rst_fill_done", 32'(fill_done), 32'd0);
    check("mid_rst_ram_addra", 32'(ram_addra), 32'd0);
    check("mid_rst_ram_dina", 32'(ram_dina), 32'd0);
    check("mid_rst_ram_wea", 32'(ram_wea), 32'd0);
    fill_q.delete();
    ref_mem[0] = 8'h5A;
    ref_mem[1] = 8'h5A;
    last_rd = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", 32'(fill_busy), 32'd0);
    cpu_op(1'b0, 4'd0, 8'h00);
    cpu_op(1'b0, 4'd2, 8'h00);

    // randomized fills with CPU traffic outside the fill range
    for (int it = 0; it < 30; it++) begin
      b   = AW'($urandom_range(0, 15));
      len = (AW + 1)'($urandom_range(0, 16));
      v   = DW'($urandom);
      fill_go(b, len, v, 1'b1);
      if (fill_busy && ($urandom_range(0, 1) == 1)) begin
        fill_start = 1'b1; fill_base = AW'($urandom); fill_len = 5'd5; fill_value = ~v;
        @(negedge clk);
        fill_start = 1'b0;
      end
      nops = (len == 5'd16) ? 0 : int'($urandom_range(0, 3));
      for (int k = 0; k < nops; k++) begin
        a = b + AW'(int'(len) + int'($urandom_range(0, 15 - int'(len))));
        cpu_op(1'($urandom), a, DW'($urandom));
      end
      wait_fill_idle();
      cpu_op(1'b0, AW'($urandom), 8'h00);
      cpu_op(1'b0, AW'($urandom), 8'h00);
    end

    repeat (3) @(negedge clk);
    check("fill_q_drained", 32'(fill_q.size()), 32'd0);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    check("cpu_wr_q_drained", 32'(cpu_wr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
